// File: rtl/pattern_round_ctrl_if.sv
// Generator-side bus of the pattern game sequencer.
// The controller (master) drives the generator's access/ld/from_manoj/
// difficulty controls and receives the generator's 21-bit concat pattern.
interface pattern_round_ctrl_if;
  logic        gen_access;
  logic        gen_ld;
  logic        gen_from_manoj;
  logic [1:0]  gen_difficulty;
  logic [20:0] pattern_in;

  modport master (
    output gen_access,
    output gen_ld,
    output gen_from_manoj,
    output gen_difficulty,
    input  pattern_in
  );

  modport slave (
    input  gen_access,
    input  gen_ld,
    input  gen_from_manoj,
    input  gen_difficulty,
    output pattern_in
  );
endinterface

// File: rtl/pattern_round_ctrl.sv
// Game sequencer for the random-segment pattern generator.
// Seeds the generator for a player-timing-dependent number of cycles, lets it
// draw for SHOW_CYCLES, blanks for two cycles, then opens a timed answer
// window and scores the player's 21-bit switch entry against the captured
// pattern. Tracks score, lives, round number and difficulty level.
// Optional build macro FAST_BONUS_EN: a correct answer given within the first
// quarter of the answer window scores 2 instead of 1.
module pattern_round_ctrl #(
  parameter int SHOW_CYCLES      = 100,
  parameter int ANSWER_CYCLES    = 1000,
  parameter int LIVES_INIT       = 3,
  parameter int ROUNDS_PER_LEVEL = 4,
  parameter int SEED_MIN         = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  submit,
  input  logic [20:0]           player_pattern,
  pattern_round_ctrl_if.master  gen,
  output logic [7:0]            score,
  output logic [2:0]            lives,
  output logic [7:0]            round_no,
  output logic                  show_active,
  output logic                  answer_open,
  output logic                  match_pulse,
  output logic                  miss_pulse,
  output logic                  game_over
);

  // One shared phase counter covers the seed, draw, blank and answer phases.
  localparam int SEED_MAX = SEED_MIN + 31;
  localparam int CNT_MAX0 = (SHOW_CYCLES > SEED_MAX) ? SHOW_CYCLES : SEED_MAX;
  localparam int CNT_MAX  = (ANSWER_CYCLES > CNT_MAX0) ? ANSWER_CYCLES : CNT_MAX0;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    DRAW,
    BLANK,
    ANSWER,
    GAME_OVER
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       lfsr;
  logic [20:0]      pat_q;
  logic [1:0]       level;

  logic [CNT_W-1:0] seed_load;
  logic             answer_hit;
  logic             timeout_hit;
  logic [8:0]       score_sum;
  logic [7:0]       score_next;
  logic             level_up;

  assign gen.gen_difficulty = level;
  assign seed_load   = CNT_W'(SEED_MIN) + CNT_W'(lfsr[4:0]);
  assign answer_hit  = (player_pattern == pat_q);
  assign timeout_hit = (cnt == CNT_W'(ANSWER_CYCLES - 1));

  // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR; seed length follows player timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Score after a correct answer (saturating) and whether it earns a level.
  always_comb begin
    score_sum = {1'b0, score} + 9'd1;
`ifdef FAST_BONUS_EN
    if (cnt < CNT_W'(ANSWER_CYCLES / 4)) score_sum = {1'b0, score} + 9'd2;
`endif
    score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
`ifdef FAST_BONUS_EN
    level_up = (level != 2'd3) &&
               ((int'(score_next) / ROUNDS_PER_LEVEL) != (int'(score) / ROUNDS_PER_LEVEL));
`else
    level_up = (level != 2'd3) && ((int'(score_next) % ROUNDS_PER_LEVEL) == 0);
`endif
  end

  // Round sequencer; every output is set on the edge that enters its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      pat_q              <= '0;
      level              <= '0;
      score              <= '0;
      lives              <= '0;
      round_no           <= '0;
      gen.gen_access     <= 1'b0;
      gen.gen_ld         <= 1'b1;
      gen.gen_from_manoj <= 1'b0;
      show_active        <= 1'b0;
      answer_open        <= 1'b0;
      match_pulse        <= 1'b0;
      miss_pulse         <= 1'b0;
      game_over          <= 1'b0;
    end else begin
      match_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
      case (state)
        IDLE, GAME_OVER: begin
          if (start) begin
            lives          <= 3'(LIVES_INIT);
            score          <= '0;
            round_no       <= '0;
            level          <= '0;
            game_over      <= 1'b0;
            gen.gen_access <= 1'b1;
            gen.gen_ld     <= 1'b0;
            cnt            <= seed_load;
            state          <= SEED;
          end
        end
        SEED: begin
          if (cnt <= CNT_W'(1)) begin
            gen.gen_ld         <= 1'b1;
            gen.gen_from_manoj <= 1'b1;
            show_active        <= 1'b1;
            cnt                <= CNT_W'(SHOW_CYCLES);
            state              <= DRAW;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DRAW: begin
          if (cnt <= CNT_W'(1)) begin
            pat_q              <= gen.pattern_in;
            gen.gen_from_manoj <= 1'b0;
            show_active        <= 1'b0;
            cnt                <= CNT_W'(2);
            state              <= BLANK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        BLANK: begin
          if (cnt <= CNT_W'(1)) begin
            answer_open <= 1'b1;
            cnt         <= '0;
            state       <= ANSWER;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ANSWER: begin
          if (submit && answer_hit) begin
            match_pulse <= 1'b1;
            score       <= score_next;
            round_no    <= round_no + 8'd1;
            if (level_up) level <= level + 2'd1;
            answer_open <= 1'b0;
            gen.gen_ld  <= 1'b0;
            cnt         <= seed_load;
            state       <= SEED;
          end else if (submit || timeout_hit) begin
            miss_pulse  <= 1'b1;
            lives       <= lives - 3'd1;
            round_no    <= round_no + 8'd1;
            answer_open <= 1'b0;
            if (lives == 3'd1) begin
              game_over      <= 1'b1;
              gen.gen_access <= 1'b0;
              state          <= GAME_OVER;
            end else begin
              gen.gen_ld <= 1'b0;
              cnt        <= seed_load;
              state      <= SEED;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_round_ctrl.sv
// Randomized self-checking bench for pattern_round_ctrl.
// Acts as the generator (drives pattern_in) and the player, and predicts
// phase lengths, score, lives, round and level from the game rules.
module tb_pattern_round_ctrl;
  localparam int SHOW  = 12;
  localparam int ANS   = 64;
  localparam int LIVES = 3;
  localparam int RPL   = 4;
  localparam int SMIN  = 4;
  localparam logic [20:0] FIXED_PAT = 21'h1F3FFE;

  logic        clk;
  logic        reset;
  logic        start;
  logic        submit;
  logic [20:0] player_pattern;
  logic [7:0]  score;
  logic [2:0]  lives;
  logic [7:0]  round_no;
  logic        show_active;
  logic        answer_open;
  logic        match_pulse;
  logic        miss_pulse;
  logic        game_over;

  pattern_round_ctrl_if gen_bus();

  pattern_round_ctrl #(
    .SHOW_CYCLES      (SHOW),
    .ANSWER_CYCLES    (ANS),
    .LIVES_INIT       (LIVES),
    .ROUNDS_PER_LEVEL (RPL),
    .SEED_MIN         (SMIN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .submit         (submit),
    .player_pattern (player_pattern),
    .gen            (gen_bus),
    .score          (score),
    .lives          (lives),
    .round_no       (round_no),
    .show_active    (show_active),
    .answer_open    (answer_open),
    .match_pulse    (match_pulse),
    .miss_pulse     (miss_pulse),
    .game_over      (game_over)
  );

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [7:0]  m_lfsr;
  int          exp_score, exp_lives, exp_round, exp_level, exp_seed_len;
  logic [20:0] last_draw_pat;
  bit          bonus_en;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference LFSR: polynomial x^8+x^6+x^5+x^4+1, stepped once per clock.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
  end

  // Safety net in case something stalls outside the bounded loops.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit noise, input bit fixed_pat);
    if (noise) begin
      start          = ($urandom % 8) == 0;
      submit         = ($urandom % 8) == 0;
      player_pattern = 21'($urandom);
    end else begin
      start  = 1'b0;
      submit = 1'b0;
    end
    gen_bus.pattern_in = fixed_pat ? FIXED_PAT : 21'($urandom);
  endtask

  // Called at a negedge while in IDLE or GAME_OVER.
  task automatic startGame();
    start        = 1'b1;
    submit       = 1'b0;
    exp_seed_len = SMIN + int'(m_lfsr[4:0]);
    @(negedge clk);
    start     = 1'b0;
    exp_score = 0;
    exp_lives = LIVES;
    exp_round = 0;
    exp_level = 0;
    checkOutput("start_lives", 32'(lives), 32'(LIVES));
    checkOutput("start_score", 32'(score), 0);
    checkOutput("start_round", 32'(round_no), 0);
    checkOutput("start_game_over", 32'(game_over), 0);
    checkOutput("start_access", 32'(gen_bus.gen_access), 1);
  endtask

  // mode 0: correct answer, 1: wrong answer, 2: no answer (timeout).
  // Called at the first negedge of a seed phase.
  task automatic playRound(input int mode, input int delay, input bit fixed_pat, input bit noise);
    int          n;
    int          seed_next;
    int          old_score;
    logic [20:0] ans;
    n = 0;
    seed_next = 0;
    while (gen_bus.gen_ld == 1'b0 && gen_bus.gen_access == 1'b1 && n < 100) begin
      n++;
      if (n == 2) checkOutput("pulse_clear", {30'd0, match_pulse, miss_pulse}, 0);
      applyStimulus(noise, fixed_pat);
      @(negedge clk);
    end
    checkOutput("seed_len", n, exp_seed_len);
    n = 0;
    while (gen_bus.gen_from_manoj && show_active && gen_bus.gen_ld && n < 200) begin
      n++;
      applyStimulus(noise, fixed_pat);
      last_draw_pat = gen_bus.pattern_in;
      @(negedge clk);
    end
    checkOutput("draw_len", n, SHOW);
    n = 0;
    while (!answer_open && gen_bus.gen_ld && !gen_bus.gen_from_manoj && !show_active && n < 10) begin
      n++;
      applyStimulus(noise, fixed_pat);
      @(negedge clk);
    end
    checkOutput("blank_len", n, 2);
    start  = 1'b0;
    submit = 1'b0;
    if (mode == 2) begin
      n = 0;
      while (answer_open && n < ANS + 5) begin
        n++;
        seed_next          = SMIN + int'(m_lfsr[4:0]);
        player_pattern     = 21'($urandom);
        gen_bus.pattern_in = fixed_pat ? FIXED_PAT : 21'($urandom);
        @(negedge clk);
      end
      checkOutput("answer_len", n, ANS);
    end else begin
      repeat (delay) begin
        gen_bus.pattern_in = fixed_pat ? FIXED_PAT : 21'($urandom);
        @(negedge clk);
      end
      checkOutput("open_at_submit", 32'(answer_open), 1);
      if (mode == 0)      ans = last_draw_pat;
      else if (fixed_pat) ans = 21'h000000;
      else                ans = last_draw_pat ^ 21'($urandom_range(1, 2097151));
      player_pattern = ans;
      submit         = 1'b1;
      seed_next      = SMIN + int'(m_lfsr[4:0]);
      @(negedge clk);
      submit = 1'b0;
    end
    if (mode == 0) begin
      old_score = exp_score;
      exp_score = old_score + ((bonus_en && delay < ANS / 4) ? 2 : 1);
      if (exp_score > 255) exp_score = 255;
      if (bonus_en) begin
        if ((exp_score / RPL) > (old_score / RPL) && exp_level < 3) exp_level++;
      end else begin
        if ((exp_score % RPL) == 0 && exp_level < 3) exp_level++;
      end
    end else begin
      exp_lives--;
    end
    exp_round = (exp_round + 1) % 256;
    checkOutput("match_pulse", 32'(match_pulse), (mode == 0) ? 1 : 0);
    checkOutput("miss_pulse", 32'(miss_pulse), (mode != 0) ? 1 : 0);
    checkOutput("score", 32'(score), exp_score);
    checkOutput("lives", 32'(lives), exp_lives);
    checkOutput("round_no", 32'(round_no), exp_round);
    checkOutput("difficulty", 32'(gen_bus.gen_difficulty), exp_level);
    checkOutput("answer_closed", 32'(answer_open), 0);
    checkOutput("game_over", 32'(game_over), (exp_lives == 0) ? 1 : 0);
    if (exp_lives == 0) begin
      checkOutput("over_access", 32'(gen_bus.gen_access), 0);
      @(negedge clk);
      checkOutput("over_pulse_clear", {30'd0, match_pulse, miss_pulse}, 0);
      checkOutput("over_hold", 32'(game_over), 1);
    end else begin
      checkOutput("seed_reentry_ld", 32'(gen_bus.gen_ld), 0);
      exp_seed_len = seed_next;
    end
  endtask

  // Main sequence: reset, reset mid-draw, a losing game, then a long random game.
  initial begin
    int n;
    int r;
`ifdef FAST_BONUS_EN
    bonus_en = 1'b1;
`else
    bonus_en = 1'b0;
`endif
    start = 1'b0;
    submit = 1'b0;
    player_pattern = '0;
    gen_bus.pattern_in = '0;
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_ld", 32'(gen_bus.gen_ld), 1);
    checkOutput("rst_access", 32'(gen_bus.gen_access), 0);
    checkOutput("rst_from_manoj", 32'(gen_bus.gen_from_manoj), 0);
    checkOutput("rst_outputs", {score, lives, round_no, show_active, answer_open,
                                match_pulse, miss_pulse, game_over, gen_bus.gen_difficulty}, 0);
    reset = 1'b0;
    @(negedge clk);

    startGame();
    n = 0;
    while (!gen_bus.gen_from_manoj && n < 100) begin
      applyStimulus(1'b0, 1'b0);
      @(negedge clk);
      n++;
    end
    checkOutput("reach_draw", 32'(gen_bus.gen_from_manoj), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_access", 32'(gen_bus.gen_access), 0);
    checkOutput("mid_rst_ld", 32'(gen_bus.gen_ld), 1);
    checkOutput("mid_rst_score", 32'(score), 0);
    checkOutput("mid_rst_lives", 32'(lives), 0);
    checkOutput("mid_rst_game_over", 32'(game_over), 0);
    checkOutput("mid_rst_show", 32'(show_active), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    startGame();
    playRound(0, 5, 1'b1, 1'b1);
    repeat (3) playRound(1, 3, 1'b1, 1'b1);

    startGame();
    playRound(2, 0, 1'b0, 1'b1);
    playRound(0, 10, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) playRound(0, $urandom_range(0, ANS - 1), 1'b0, 1'b1);
    playRound(0, ANS - 1, 1'b0, 1'b0);
    for (int i = 0; i < 20 && exp_lives > 0; i++) begin
      r = $urandom % 10;
      playRound((r < 6) ? 0 : ((r < 9) ? 1 : 2), $urandom_range(0, ANS - 1), 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pattern_round_ctrl.md
Name: pattern_round_ctrl

Overview:
- Game sequencer for the random-segment pattern generator. Drives the generator's access, ld, from_manoj and difficulty inputs, and captures the 21-bit concat pattern.
- Blanks the display, then runs a timed answer window and compares the player's 21-bit switch entry against the captured pattern.
- Tracks score, lives, round and difficulty level; sits between the top-level button/switch logic and the generator.

Parameters:
- SHOW_CYCLES, 100, cycles the drawn pattern stays on the displays before blanking (min 2).
- ANSWER_CYCLES, 1000, answer-window timeout in cycles.
- LIVES_INIT, 3, lives at game start (1..7).
- ROUNDS_PER_LEVEL, 4, correct answers needed to raise difficulty by one.
- SEED_MIN, 4, minimum ld-low cycles in the seed phase.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a game from IDLE or GAME_OVER
- submit  in  1  single-cycle pulse; player answer strobe
- player_pattern  in  21  player switch entry, same bit order as concat
- pattern_in  in  21  generator concat output
- gen_access  out  1  generator access enable
- gen_ld  out  1  generator ld
- gen_from_manoj  out  1  generator display-write enable
- gen_difficulty  out  2  generator difficulty
- score  out  8  correct-answer count, saturates at 255
- lives  out  3  remaining lives
- round_no  out  8  current round, wraps 255->0
- show_active  out  1  high while the pattern is visible
- answer_open  out  1  high while submit is accepted
- match_pulse  out  1  one-cycle pulse on a correct answer
- miss_pulse  out  1  one-cycle pulse on a wrong answer or timeout
- game_over  out  1  high in GAME_OVER

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0 except gen_ld=1; internal 8-bit LFSR=8'hA5, counters=0.
- LFSR: x^8+x^6+x^5+x^4+1, Fibonacci form. Advances every cycle in every state, so the seed length depends on player timing.
- IDLE: gen_access=0, gen_ld=1. On start: lives=LIVES_INIT, score=0, round_no=0, level=0, then go to SEED.
- SEED: gen_access=1, gen_ld=0.
  - On entry, load the seed counter with SEED_MIN + LFSR[4:0].
  - Stay until the counter expires, then go to DRAW.
- DRAW: gen_ld=1, gen_from_manoj=1, show_active=1.
  - Stay SHOW_CYCLES cycles.
  - On the last cycle, register pattern_in into pat_q, then go to BLANK.
- BLANK: gen_from_manoj=0, gen_ld=1 for exactly 2 cycles so the generator clears and parks, then go to ANSWER.
- ANSWER: answer_open=1; timeout counter runs from 0.
  - submit with player_pattern==pat_q: match_pulse; score +1 (saturating); round_no +1.
  - If the new score is a multiple of ROUNDS_PER_LEVEL and level<3, level +1. Then go to SEED.
  - submit with mismatch, or counter reaches ANSWER_CYCLES-1 with no submit: miss_pulse; lives -1; round_no +1.
  - After a miss, go to GAME_OVER if the new lives==0, else SEED.
  - submit on the same cycle as timeout counts as a submit.
- GAME_OVER: game_over=1, gen_access=0. start restarts exactly as from IDLE.
- gen_difficulty = level at all times; level held 0..3.
- submit outside ANSWER is ignored. start outside IDLE/GAME_OVER is ignored.
- All outputs are registered. match_pulse/miss_pulse assert on the cycle after the deciding edge and are never both high.
- Reset asserted mid-round returns to IDLE immediately; the captured pattern is discarded.

Optional Feature:
- FAST_BONUS_EN defined: a correct submit while the timeout counter < ANSWER_CYCLES/4 adds 2 to score instead of 1 (saturating at 255). The level check uses the new score and fires if a multiple of ROUNDS_PER_LEVEL was crossed.
- Undefined: every correct answer adds exactly 1.

Test Plan:
- Reset asserted mid-DRAW -> next cycle: gen_access=0, gen_ld=1, score=0, lives=0, game_over=0.
- start, model generator returns 21'h1F3FFE; submit 21'h1F3FFE in ANSWER -> match_pulse 1 cycle, score=1, round_no=1, gen_ld low again in SEED.
- start, submit 21'h000000 against pattern 21'h1F3FFE -> miss_pulse, lives 3->2. Repeat twice more -> lives=0, game_over=1, gen_access=0.
- start, no submit -> miss_pulse exactly ANSWER_CYCLES cycles after answer_open rises; lives=2.
- 4 consecutive correct answers (ROUNDS_PER_LEVEL=4) -> gen_difficulty 0->1 after the 4th. After 16 correct, gen_difficulty stays 3.
- DRAW/BLANK timing check: gen_from_manoj high exactly SHOW_CYCLES cycles, then low 2 cycles before answer_open.
  - With FAST_BONUS_EN, a correct submit 10 cycles into ANSWER -> score +2.
